uart_bus_dumper: RTL and testbench
==================================

UART_BUS_DUMPER -- requirements
Module: uart_bus_dumper

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, meaning clock cycles per UART bit (27 MHz / 115200).
REQ-002 Parameter FIFO_DEPTH, default 8, meaning byte FIFO entries; SHALL be a power of two, at least 4.
REQ-003 Parameter ADDR_W, default 14, meaning bus address width.
REQ-004 Port clk, input, 1, meaning the single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 Port start, input, 1, meaning a one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 Port base_addr, input, ADDR_W, meaning the first word address; latched on an accepted start.
REQ-008 Port word_count, input, 8, meaning the number of 32-bit words to dump; latched on an accepted start.
REQ-009 Port bus_address, output, ADDR_W, meaning the current word address.
REQ-010 Port bus_datao, input, 32, meaning read data from the bus.
REQ-011 Port bus_req, output, 1, meaning a bus request.
REQ-012 Port bus_available, input, 1, meaning the arbiter has granted the bus.
REQ-013 Port bus_use, output, 1, meaning the block owns the bus.
REQ-014 Port fulfilled, input, 1, meaning bus_datao is valid this cycle.
REQ-015 Port tx_pin, output, 1, meaning UART serial out, idle high.
REQ-016 Port busy, output, 1, meaning high whenever the FSM is not IDLE.
REQ-017 Port done, output, 1, meaning a one-cycle pulse when a dump has completed.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, USE, PUSH and DRAIN.
REQ-019 IDLE with start=1: latch the inputs and go to REQ; if word_count=0, go to DRAIN instead with no bus activity.
REQ-020 REQ: bus_req=1; on bus_available=1, the next cycle SHALL have bus_req=0, bus_use=1 and state USE.
REQ-021 USE: hold bus_use=1; on fulfilled=1, latch bus_datao, drop bus_use the next cycle and go to PUSH.
REQ-022 PUSH: write the 4 bytes MSB first ([31:24] first), one per cycle, and stall while the FIFO is full.
REQ-023 After the 4th byte: decrement the remaining count and increment bus_address by 1, wrapping at 2^ADDR_W; then go to REQ if the count is nonzero, else DRAIN.
REQ-024 DRAIN: when the FIFO is empty and the transmitter is idle, pulse done for 1 cycle and return to IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 bus_req and bus_use SHALL never be high in the same cycle.
REQ-027 Transmitter: pop when idle and the FIFO is non-empty; send start(0), 8 data bits LSB first, then stop(1).
REQ-028 Each transmitted bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-029 Back-to-back bytes SHALL have no idle gap; the first start bit SHALL begin the cycle after the pop.
REQ-030 A simultaneous FIFO push and pop SHALL leave the count unchanged; the pointers wrap modulo FIFO_DEPTH.

Reset
REQ-031 rst=1 SHALL force, immediately: IDLE, bus_req=0, bus_use=0, busy=0, done=0, tx_pin=1, bus_address=0, FIFO empty.
REQ-032 rst asserted mid-frame SHALL abort the frame with tx_pin high; nothing SHALL resume after release.

Configuration
REQ-033 With UART_PARITY_EN defined, an even-parity bit SHALL be sent after bit 7 and before the stop bit (11-bit frame).
REQ-034 Without UART_PARITY_EN, the frame SHALL be 10 bits with no parity logic present.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the UART frame bit-count constants and the default CLKS_PER_BIT.
REQ-036 The serializer SHALL be a sub-module, uart_tx_core (byte, valid, ready, tx_pin), instantiated once.

Verification
REQ-037 CLKS_PER_BIT=4, base_addr=0x041, word_count=1, immediate grant, data 0x48656C6C -> tx bytes 0x48,0x65,0x6C,0x6C in order; done 1 cycle after the last stop bit.
REQ-038 word_count=3, base_addr=0x3FFF -> addresses 0x3FFF, 0x0000, 0x0001 in order; 12 bytes sent.
REQ-039 bus_available held low 50 cycles -> bus_req high throughout, bus_use low, tx_pin idle high.
REQ-040 FIFO_DEPTH=4, word_count=2, fulfilled immediate -> PUSH stalls on full; no byte lost or duplicated.
REQ-041 rst pulse in the middle of the 2nd byte -> tx_pin=1 and outputs at their reset values the same cycle; the next start works normally.
REQ-042 UART_PARITY_EN defined, byte 0x07 -> frame 0,1,1,1,0,0,0,0,0,1(parity),1(stop).

Source files
------------

// File: rtl/uart_bus_dumper_pkg.sv
// Shared types and constants for the bus-to-UART dumper.
// Build option: define UART_PARITY_EN to add an even-parity bit (11-bit frame).
package uart_bus_dumper_pkg;
  typedef enum logic [2:0] {IDLE, REQ, USE, PUSH, DRAIN} state_t;

  localparam int DATA_BITS = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif
  localparam int CLKS_PER_BIT_DEF = 234;
endpackage

// File: rtl/uart_bus_dumper_tx.sv
// uart_tx_core: byte serializer; start bit, data LSB first, optional parity, stop bit.
// Build option: UART_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_core
  import uart_bus_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_byte,
  input  logic                 valid,
  output logic                 ready,
  output logic                 idle,
  output logic                 tx_pin
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(FRAME_BITS);

  logic                  active;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame;
  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_idx;
  logic                  bit_end, last_tick, accept;

  always_comb begin
`ifdef UART_PARITY_EN
    frame = {1'b1, ^tx_byte, tx_byte, 1'b0};
`else
    frame = {1'b1, tx_byte, 1'b0};
`endif
  end

  assign bit_end   = active && (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_tick = bit_end && (bit_idx == BW'(FRAME_BITS - 1));
  // Accepting during the final stop-bit cycle keeps back-to-back frames gapless.
  assign ready     = !active || last_tick;
  assign idle      = !active;
  assign accept    = valid && ready;
  assign tx_pin    = active ? shreg[0] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      shreg   <= '1;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      active  <= 1'b1;
      shreg   <= frame;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (last_tick) begin
      active  <= 1'b0;
    end else if (bit_end) begin
      clk_cnt <= '0;
      bit_idx <= bit_idx + BW'(1);
      shreg   <= shreg >> 1;
    end else if (active) begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/uart_bus_dumper.sv
// Reads word_count 32-bit words from the bus and streams them MSB byte first over UART.
// Build option: UART_PARITY_EN (see uart_tx_core).
module uart_bus_dumper
  import uart_bus_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 14
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        word_count,
  output logic [ADDR_W-1:0] bus_address,
  input  logic [31:0]       bus_datao,
  output logic              bus_req,
  input  logic              bus_available,
  output logic              bus_use,
  input  logic              fulfilled,
  output logic              tx_pin,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(FIFO_DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        remaining;
  logic [31:0]       word;
  logic [1:0]        byte_idx;
  logic [7:0]        push_byte;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, empty, push, pop;
  logic              tx_ready, tx_idle;

  assign full        = (count == (PW+1)'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign push        = (state == PUSH) && !full;
  assign pop         = !empty && tx_ready;
  assign bus_address = addr;
  assign busy        = (state != IDLE);

  always_comb begin
    case (byte_idx)
      2'd0:    push_byte = word[31:24];
      2'd1:    push_byte = word[23:16];
      2'd2:    push_byte = word[15:8];
      default: push_byte = word[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bus_req  = 1'b0;
    bus_use  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = (word_count == 8'd0) ? DRAIN : REQ;
      REQ: begin
        bus_req = 1'b1;
        if (bus_available) state_nx = USE;
      end
      USE: begin
        bus_use = 1'b1;
        if (fulfilled) state_nx = PUSH;
      end
      PUSH:  if (push && byte_idx == 2'd3) state_nx = (remaining == 8'd1) ? DRAIN : REQ;
      DRAIN: if (empty && tx_idle) begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr      <= base_addr;
          remaining <= word_count;
        end
        USE: if (fulfilled) begin
          word     <= bus_datao;
          byte_idx <= '0;
        end
        PUSH: if (push) begin
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            remaining <= remaining - 8'd1;
            addr      <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Byte FIFO; pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_byte (mem[rd_ptr]),
    .valid   (!empty),
    .ready   (tx_ready),
    .idle    (tx_idle),
    .tx_pin  (tx_pin)
  );
endmodule

// File: tb/tb_uart_bus_dumper.sv
// Self-checking bench: random bus words decoded off tx_pin and compared to a frame-level model.
module tb_uart_bus_dumper;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 14;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic          clk = 1'b0;
  logic          rst, start, bus_available, fulfilled;
  logic [AW-1:0] base_addr, bus_address;
  logic [7:0]    word_count;
  logic [31:0]   bus_datao;
  logic          bus_req, bus_use, tx_pin, busy, done;

  int vectors = 0;
  int miscompares = 0;

  uart_bus_dumper #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .bus_address(bus_address), .bus_datao(bus_datao), .bus_req(bus_req),
    .bus_available(bus_available), .bus_use(bus_use), .fulfilled(fulfilled),
    .tx_pin(tx_pin), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bus memory contents: seeded hash of the address, or one fixed word.
  logic [31:0] seed = 32'h0;
  logic [31:0] fixed_word = 32'h0;
  bit          use_fixed = 1'b0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return use_fixed ? fixed_word : (seed ^ (32'(a) * 32'h9E3779B1));
  endfunction

  // Expected serial frame, index = bit time order.
  function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
    logic [FB-1:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    if (FB == 11) f[9] = 1'($countones(b) % 2);
    f[FB-1] = 1'b1;
    return f;
  endfunction

  // Bus responder: answers bus_use after a random latency.
  int            lat_max = 0;
  int            lat_cnt = 0;
  int            lat_tgt = 0;
  logic [AW-1:0] addr_q[$];

  initial begin
    fulfilled = 1'b0;
    bus_datao = '0;
    forever begin
      @(posedge clk); #1;
      fulfilled = 1'b0;
      if (!rst && bus_use) begin
        if (lat_cnt >= lat_tgt) begin
          fulfilled = 1'b1;
          bus_datao = mem_word(bus_address);
          addr_q.push_back(bus_address);
          lat_cnt = 0;
          lat_tgt = $urandom_range(lat_max, 0);
        end else lat_cnt++;
      end else lat_cnt = 0;
    end
  end

  // Line monitor: captures whole frames, flags any level change inside a bit.
  int            cyc = 0;
  bit            mon_act = 1'b0;
  int            mon_n = 0;
  logic [FB-1:0] mon_bits;
  logic [FB-1:0] frames[$];
  int            starts[$];
  int            done_cycles[$];
  int            last_end = 0;
  int            glitches = 0;
  int            conflicts = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus_req === 1'b1 && bus_use === 1'b1) conflicts++;
    if (done === 1'b1) done_cycles.push_back(cyc);
    if (rst) mon_act = 1'b0;
    else begin
      if (!mon_act && tx_pin === 1'b0) begin
        mon_act = 1'b1; mon_n = 0; mon_bits = '0;
        starts.push_back(cyc);
      end
      if (mon_act) begin
        if (mon_n % CPB == 0) mon_bits[mon_n / CPB] = tx_pin;
        else if (tx_pin !== mon_bits[mon_n / CPB]) glitches++;
        if (mon_n == FB*CPB - 1) begin
          frames.push_back(mon_bits);
          last_end = cyc;
          mon_act = 1'b0;
        end else mon_n++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One complete dump; grant_delay holds bus_available low, poke retries start mid-dump.
  task automatic run_dump(input logic [AW-1:0] base, input int wc, input int grant_delay,
                          input bit poke, input string name);
    logic [FB-1:0] exp_f[$];
    logic [AW-1:0] exp_a[$];
    logic [AW-1:0] a;
    logic [31:0]   w;
    int d0, g0, c0, budget, bad, wait_bad, gaps;
    for (int i = 0; i < wc; i++) begin
      a = base + AW'(i);
      w = mem_word(a);
      exp_a.push_back(a);
      for (int k = 0; k < 4; k++) exp_f.push_back(frame_of(8'((w >> (24 - 8*k)) & 32'hFF)));
    end
    frames.delete(); starts.delete(); addr_q.delete();
    d0 = done_cycles.size(); g0 = glitches; c0 = conflicts; wait_bad = 0;
    budget = (4*wc + 2)*FB*CPB + 20*wc + grant_delay + 100;
    bus_available = (grant_delay == 0);
    base_addr = base; word_count = 8'(wc); start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < budget && done_cycles.size() == d0; i++) begin
      if (i < grant_delay && (bus_req !== 1'b1 || bus_use !== 1'b0 || tx_pin !== 1'b1)) wait_bad++;
      bus_available = (i >= grant_delay);
      start = (poke && i == 12);
      if (start) begin base_addr = ~base; word_count = 8'd7; end
      tick(1);
    end
    start = 1'b0;
    tick(3);

    vectors++;
    if (done_cycles.size() != d0 + 1) begin
      miscompares++;
      $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cycles.size() - d0);
    end
    vectors++;
    if (frames.size() != exp_f.size()) begin
      miscompares++;
      $display("FAIL %s byte_count: got %0d, expected %0d", name, frames.size(), exp_f.size());
    end
    bad = 0;
    for (int i = 0; i < frames.size() && i < exp_f.size(); i++) if (frames[i] !== exp_f[i]) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s frame_bits: %0d frames differ, first got %b expected %b",
               name, bad, frames.size() > 0 ? frames[0] : '0, exp_f.size() > 0 ? exp_f[0] : '0);
    end
    bad = 0;
    if (addr_q.size() != exp_a.size()) bad++;
    else for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== exp_a[i]) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s addresses: got %0d reads with %0d errors, expected %0d reads",
               name, addr_q.size(), bad, exp_a.size());
    end
    if (exp_f.size() > 0 && done_cycles.size() > d0) begin
      vectors++;
      if (done_cycles[d0] != last_end + 1) begin
        miscompares++;
        $display("FAIL %s done_timing: got cycle %0d, expected %0d", name, done_cycles[d0], last_end + 1);
      end
    end
    gaps = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != FB*CPB) gaps++;
    vectors++;
    if (gaps != 0) begin
      miscompares++;
      $display("FAIL %s frame_spacing: got %0d gaps, expected 0", name, gaps);
    end
    vectors++;
    if (glitches - g0 != 0) begin
      miscompares++;
      $display("FAIL %s bit_width: got %0d unstable bits, expected 0", name, glitches - g0);
    end
    vectors++;
    if (conflicts - c0 != 0) begin
      miscompares++;
      $display("FAIL %s req_use_overlap: got %0d cycles, expected 0", name, conflicts - c0);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_after_done: got %b, expected 0", name, busy);
    end
    if (grant_delay > 0) begin
      vectors++;
      if (wait_bad != 0) begin
        miscompares++;
        $display("FAIL %s grant_wait: got %0d bad cycles, expected 0", name, wait_bad);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    vectors++;
    if ({tx_pin, bus_req, bus_use, busy, done} !== 5'b10000 || bus_address !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got tx=%b req=%b use=%b busy=%b done=%b addr=%h, expected 1 0 0 0 0 0",
               tx_pin, bus_req, bus_use, busy, done, bus_address);
    end
    rst = 1'b0;
    tick(2);
    vectors++;
    if (tx_pin !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got tx=%b busy=%b, expected 1 0", tx_pin, busy);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b[4] = '{8'h48, 8'h65, 8'h6C, 8'h6C};
    int bad;
    use_fixed = 1'b1; fixed_word = 32'h48656C6C; lat_max = 0;
    run_dump(14'h041, 1, 0, 1'b0, "single_word");
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= frames.size() || frames[i][8:1] !== exp_b[i]) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL single_word_bytes: got %0d wrong bytes, expected 48 65 6C 6C", bad);
    end
    vectors++;
    if (addr_q.size() != 1 || addr_q[0] !== 14'h041) begin
      miscompares++;
      $display("FAIL single_word_addr: got %0d reads, expected one read at 041", addr_q.size());
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_frame_format();
    logic [FB-1:0] exp07;
`ifdef UART_PARITY_EN
    exp07 = 11'b11000001110;
`else
    exp07 = 10'b1000001110;
`endif
    use_fixed = 1'b1; fixed_word = 32'h07070707; lat_max = 0;
    run_dump(14'h100, 1, 0, 1'b0, "frame_format");
    vectors++;
    if (frames.size() == 0 || frames[0] !== exp07) begin
      miscompares++;
      $display("FAIL frame_07: got %b, expected %b", frames.size() > 0 ? frames[0] : '0, exp07);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_addr_wrap();
    seed = $urandom; lat_max = 1;
    run_dump(14'h3FFF, 3, 0, 1'b0, "addr_wrap");
    vectors++;
    if (addr_q.size() != 3 || addr_q[0] !== 14'h3FFF || addr_q[1] !== 14'h0000 || addr_q[2] !== 14'h0001) begin
      miscompares++;
      $display("FAIL addr_wrap_seq: got %0d reads, expected 3FFF 0000 0001", addr_q.size());
    end
  endtask

  task automatic test_grant_wait();
    seed = $urandom; lat_max = 2;
    run_dump(14'(($urandom)), 1, 50, 1'b0, "grant_wait");
  endtask

  task automatic test_zero_count();
    run_dump(14'h0123, 0, 0, 1'b0, "zero_count");
  endtask

  task automatic test_fifo_stall();
    seed = $urandom; lat_max = 0;
    run_dump(14'(($urandom)), 2, 0, 1'b0, "fifo_stall");
  endtask

  task automatic test_start_ignored();
    seed = $urandom; lat_max = 0;
    run_dump(14'h0200, 2, 0, 1'b1, "start_ignored");
  endtask

  task automatic test_reset_mid_frame();
    int i, bad;
    use_fixed = 1'b1; fixed_word = 32'h48001234; lat_max = 0; bus_available = 1'b1;
    frames.delete(); starts.delete(); addr_q.delete();
    base_addr = 14'h0055; word_count = 8'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (i = 0; i < 2000 && !(frames.size() == 1 && mon_act); i++) tick(1);
    vectors++;
    if (!(frames.size() == 1 && mon_act)) begin
      miscompares++;
      $display("FAIL mid_reset_setup: got %0d frames, expected second byte in flight", frames.size());
    end
    tick(5);
    rst = 1'b1;
    #1;
    vectors++;
    if ({tx_pin, bus_req, bus_use, busy, done} !== 5'b10000 || bus_address !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got tx=%b req=%b use=%b busy=%b done=%b addr=%h, expected 1 0 0 0 0 0",
               tx_pin, bus_req, bus_use, busy, done, bus_address);
    end
    tick(2);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (tx_pin !== 1'b1 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0 || frames.size() != 1) begin
      miscompares++;
      $display("FAIL mid_reset_quiet: got %0d active cycles, %0d frames, expected 0 and 1", bad, frames.size());
    end
    use_fixed = 1'b0; seed = $urandom;
    run_dump(14'(($urandom)), 1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      seed = $urandom; lat_max = $urandom_range(3, 0);
      run_dump(14'(($urandom)), $urandom_range(3, 1), $urandom_range(5, 0), 1'b0, "random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bus_available = 1'b0;
    base_addr = '0; word_count = '0;
    test_reset();
    test_single_word();
    test_frame_format();
    test_addr_wrap();
    test_grant_wait();
    test_zero_count();
    test_fifo_stall();
    test_start_ignored();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
